// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES-128 key expander
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SUB     = 2'd2,
        MIX     = 2'd3
    } ke_state_t;

    localparam int         NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1B;

    // GF(2^8) multiply-by-x, reducing modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/key_expand_seq_subword.sv
// rtl/key_expand_seq_subword.sv - AES SubWord: S-box applied to each byte of a word
//
// Ports:
//   word_in  - 32-bit input word
//   word_out - 32-bit word with every byte substituted through the AES S-box
module key_expand_seq_subword (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Byte x of the table lives at bits [2047-8x -: 8] (row-major, first entry in the MSBs)
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // 2047 - 8x equals the bitwise inverse of {x, 3'b000} in 11 bits
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] top_bit;
        top_bit = {~x, 3'b111};
        return SBOX[top_bit -: 8];
    endfunction

    assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                       sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/key_expand_seq.sv
// rtl/key_expand_seq.sv - sequential AES-128 key expansion with valid/ready round-key output
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - begin expanding key_in (only looked at in IDLE)
//   key_in   - 128-bit cipher key, w0 in [127:96] .. w3 in [31:0]
//   busy     - high whenever not IDLE
//   rk_valid - rk_out/rk_round carry a round key
//   rk_ready - consumer accepts the round key when rk_valid && rk_ready
//   rk_round - index 0..10 of the round key on rk_out
//   rk_out   - current round key, same word order as key_in
//   done     - one-cycle pulse when round key 10 is accepted
module key_expand_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    ke_state_t    state, state_next;
    logic [127:0] key_reg, key_next;
    logic [3:0]   round, round_next;
    logic [7:0]   rcon, rcon_next;
    logic [31:0]  sub_reg, sub_next;
    logic [31:0]  sub_word;
    logic [31:0]  t_word, w0n, w1n, w2n, w3n;
    logic         accept;

    // Single S-box path, fed with RotWord(w3)
    key_expand_seq_subword u_subword (
        .word_in  ({key_reg[23:0], key_reg[31:24]}),
        .word_out (sub_word)
    );

    assign t_word = sub_reg ^ {rcon, 24'h0};
    assign w0n    = key_reg[127:96] ^ t_word;
    assign w1n    = key_reg[95:64]  ^ w0n;
    assign w2n    = key_reg[63:32]  ^ w1n;
    assign w3n    = key_reg[31:0]   ^ w2n;

    assign accept = (state == PRESENT) && rk_ready;

    always_comb begin
        state_next = state;
        key_next   = key_reg;
        round_next = round;
        rcon_next  = rcon;
        sub_next   = sub_reg;
        unique case (state)
            IDLE: begin
                if (start) begin
                    key_next   = key_in;
                    round_next = 4'd0;
                    rcon_next  = RCON_INIT;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (accept) begin
                    state_next = (round == LAST_ROUND) ? IDLE : SUB;
                end
            end
            SUB: begin
                sub_next   = sub_word;
                state_next = MIX;
            end
            MIX: begin
                key_next   = {w0n, w1n, w2n, w3n};
                round_next = round + 4'd1;
                rcon_next  = xtime(rcon);
                state_next = PRESENT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            key_reg <= '0;
            round   <= 4'd0;
            rcon    <= RCON_INIT;
            sub_reg <= '0;
        end else begin
            state   <= state_next;
            key_reg <= key_next;
            round   <= round_next;
            rcon    <= rcon_next;
            sub_reg <= sub_next;
        end
    end

    assign busy     = (state != IDLE);
    assign rk_valid = (state == PRESENT);
    assign rk_round = round;
    assign rk_out   = key_reg;
    assign done     = accept && (round == LAST_ROUND);

endmodule

// File: tb/tb_key_expand_seq.sv
// tb/tb_key_expand_seq.sv - directed self-checking bench for key_expand_seq
module tb_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] exp_rk    [11];
    bit           exp_known [11];

    key_expand_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_round (rk_round),
        .rk_out   (rk_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fips();
        exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) exp_known[i] = 1'b1;
    endtask

    task automatic load_zero();
        for (int i = 0; i < 11; i++) begin
            exp_known[i] = 1'b0;
            exp_rk[i]    = '0;
        end
        exp_known[0]  = 1'b1;
        exp_known[1]  = 1'b1;
        exp_known[10] = 1'b1;
        exp_rk[1]     = 128'h62636363626363636263636362636363;
        exp_rk[10]    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    endtask

    // Runs one expansion; cyc is 1 in the cycle right after start is sampled.
    // Returns in the cycle where round key 10 is accepted.
    task automatic run_seq(input logic [127:0] key, input bit rand_ready,
                           input bit check_timing, input bit inject4);
        int           cyc, next_round, done_cnt, done_cyc;
        bit           stalled, injected;
        logic [127:0] held_out;
        logic [3:0]   held_round;
        for (int i = 0; i < 40 && busy; i++) step();
        check("idle_before_start", {127'd0, busy}, 128'd0);
        key_in = key;
        start  = 1'b1;
        step();
        start      = 1'b0;
        cyc        = 1;
        next_round = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        stalled    = 1'b0;
        injected   = 1'b0;
        held_out   = '0;
        held_round = '0;
        for (int i = 0; i < 600 && next_round < 11; i++) begin
            start    = 1'b0;
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) begin
                check("hold_valid", {127'd0, rk_valid}, 128'd1);
                check("hold_out", rk_out, held_out);
                check("hold_round", {124'd0, rk_round}, {124'd0, held_round});
            end
            if (rk_valid) begin
                check("round_index", {124'd0, rk_round}, 128'(next_round));
                if (inject4 && !injected && rk_round == 4'd4) begin
                    start    = 1'b1;
                    key_in   = ~key;
                    injected = 1'b1;
                end
                if (rk_ready) begin
                    if (exp_known[next_round])
                        check($sformatf("rk%0d", next_round), rk_out, exp_rk[next_round]);
                    if (check_timing)
                        check($sformatf("time_rk%0d", next_round), 128'(cyc), 128'(1 + 3 * next_round));
                    next_round++;
                    stalled = 1'b0;
                end else begin
                    stalled    = 1'b1;
                    held_out   = rk_out;
                    held_round = rk_round;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (next_round < 11) begin
                step();
                cyc++;
            end
        end
        check("seq_complete", 128'(next_round), 128'd11);
        check("done_count", 128'(done_cnt), 128'd1);
        if (check_timing) check("done_cycle", 128'(done_cyc), 128'd31);
    endtask

    initial begin
        int k;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_valid", {127'd0, rk_valid}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_round", {124'd0, rk_round}, 128'd0);
        check("rst_out", rk_out, 128'd0);
        rst_n = 1'b1;
        step();
        check("idle_no_start", {127'd0, busy}, 128'd0);

        // FIPS-197 key, ready held high
        load_fips();
        run_seq(FIPS_KEY, 1'b0, 1'b1, 1'b0);

        // start in the final-acceptance cycle is ignored, next cycle's start is honoured
        key_in = FIPS_KEY;
        start  = 1'b1;
        step();
        check("start_at_done_busy", {127'd0, busy}, 128'd0);
        check("start_at_done_valid", {127'd0, rk_valid}, 128'd0);
        step();
        start = 1'b0;
        check("restart_valid", {127'd0, rk_valid}, 128'd1);
        check("restart_round", {124'd0, rk_round}, 128'd0);
        check("restart_key", rk_out, FIPS_KEY);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        // All-zero key
        load_zero();
        run_seq(128'd0, 1'b0, 1'b1, 1'b0);

        // FIPS key with random backpressure
        load_fips();
        run_seq(FIPS_KEY, 1'b1, 1'b0, 1'b0);

        // start with another key during round 4 is ignored
        run_seq(FIPS_KEY, 1'b0, 1'b1, 1'b1);

        // Reset during SUB of round 6
        for (int i = 0; i < 40 && busy; i++) step();
        key_in   = FIPS_KEY;
        rk_ready = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!(rk_valid && rk_round == 4'd6) && k < 100) begin
            step();
            k++;
        end
        check("reach_rk6", {124'd0, rk_round}, 128'd6);
        step();
        check("in_sub_busy", {127'd0, busy}, 128'd1);
        check("in_sub_valid", {127'd0, rk_valid}, 128'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {127'd0, busy}, 128'd0);
        check("midrst_valid", {127'd0, rk_valid}, 128'd0);
        check("midrst_done", {127'd0, done}, 128'd0);
        check("midrst_round", {124'd0, rk_round}, 128'd0);
        check("midrst_out", rk_out, 128'd0);
        #1;
        rst_n = 1'b1;
        repeat (5) step();
        check("no_resume_busy", {127'd0, busy}, 128'd0);
        check("no_resume_out", rk_out, 128'd0);
        run_seq(FIPS_KEY, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
